// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit indices and FSM states for the alu_exec stage
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned shift-add multiplier, one multiplier bit per clock
// First partial product is taken on the start edge; done is high once all WIDTH bits are in.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     left;
  logic               active;

  assign done    = active && (left == '0);
  assign product = acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      left   <= '0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      left   <= SHW'(WIDTH-1);
      active <= 1'b1;
    end else if (active) begin
      if (left == '0) begin
        active <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        left   <= left - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - ALU execute stage: registered result/flags and en_out pulse
// Define ALU_MUL_EN to add the iterative MUL opcode, the MUL_RUN state and busy.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             en_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] res;
  logic             c_f;
  logic             v_f;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_x;
  logic [WIDTH:0]   shr_x;
  logic [WIDTH:0]   sar_x;
  logic [SHW-1:0]   amt;
  logic             take_single;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    amt   = alu_b[SHW-1:0];
    sum   = {1'b0, alu_a} + {1'b0, alu_b};
    diff  = {1'b0, alu_a} - {1'b0, alu_b};
    shl_x = {1'b0, alu_a} << amt;
    shr_x = {alu_a, 1'b0} >> amt;
    sar_x = $unsigned($signed({alu_a, 1'b0}) >>> amt);
    res   = alu_a;
    c_f   = 1'b0;
    v_f   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c_f = sum[WIDTH];
        v_f = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res = diff[WIDTH-1:0];
        c_f = diff[WIDTH];
        v_f = (alu_a[MSB] != alu_b[MSB]) && (diff[MSB] != alu_a[MSB]);
      end
      OP_AND: res = alu_a & alu_b;
      OP_OR:  res = alu_a | alu_b;
      OP_XOR: res = alu_a ^ alu_b;
      OP_NOT: res = ~alu_a;
      OP_SHL: begin
        res = shl_x[WIDTH-1:0];
        c_f = shl_x[WIDTH];
      end
      OP_SHR: begin
        res = shr_x[WIDTH:1];
        c_f = shr_x[0];
      end
      OP_SAR: begin
        res = sar_x[WIDTH:1];
        c_f = sar_x[0];
      end
      OP_MOV: res = alu_b;
      default: res = alu_a;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH-1);

  state_t             state;
  logic [SHW-1:0]     count;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  assign take_single = en_in && (state == ST_IDLE) && (alu_op != OP_MUL);
  assign mul_start   = en_in && (state == ST_IDLE) && (alu_op == OP_MUL);
  assign busy        = (state == ST_MUL_RUN);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (alu_a),
    .b       (alu_b),
    .done    (mul_done),
    .product (product)
  );
`else
  assign take_single = en_in;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out <= '0;
      flags   <= '0;
      en_out  <= 1'b0;
`ifdef ALU_MUL_EN
      state   <= ST_IDLE;
      count   <= '0;
`endif
    end else begin
      en_out <= 1'b0;
      if (take_single) begin
        if (alu_op != OP_CMP) alu_out <= res;
        flags[FLG_N] <= res[MSB];
        flags[FLG_Z] <= (res == '0);
        flags[FLG_C] <= c_f;
        flags[FLG_V] <= v_f;
        en_out       <= 1'b1;
      end
`ifdef ALU_MUL_EN
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (mul_start) state <= ST_MUL_RUN;
        end
        ST_MUL_RUN: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_IDLE;
            count <= '0;
          end
          if (mul_done) begin
            alu_out      <= product[WIDTH-1:0];
            flags[FLG_N] <= product[MSB];
            flags[FLG_Z] <= (product[WIDTH-1:0] == '0);
            flags[FLG_C] <= |product[2*WIDTH-1:WIDTH];
            flags[FLG_V] <= 1'b0;
            en_out       <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec (MUL cases under ALU_MUL_EN)
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_in = 1'b0;
  logic [15:0] alu_a = '0;
  logic [15:0] alu_b = '0;
  logic [3:0]  alu_op = '0;
  logic [15:0] alu_out;
  logic [3:0]  flags;
  logic        en_out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_in   (en_in),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .flags   (flags),
    .en_out  (en_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions, 16-bit datapath.
  function automatic void ref_alu(input int op, input int a, input int b, input int prev,
                                  output int out, output int fl);
    int r, c, v, sa, sb, s, amt;
    sa  = (a >= 32768) ? a - 65536 : a;
    sb  = (b >= 32768) ? b - 65536 : b;
    amt = b % 16;
    r = a; c = 0; v = 0;
    case (op)
      0: begin s = a + b; r = s % 65536; c = int'(s > 65535);
               s = sa + sb; v = int'(s > 32767 || s < -32768); end
      1, 9: begin r = (a - b + 65536) % 65536; c = int'(a < b);
               s = sa - sb; v = int'(s > 32767 || s < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - a;
      6: begin r = (a << amt) % 65536; c = (amt != 0) ? (a >> (16 - amt)) & 1 : 0; end
      7: begin r = a >> amt; c = (amt != 0) ? (a >> (amt - 1)) & 1 : 0; end
      8: begin r = (sa >>> amt) & 65535; c = (amt != 0) ? (a >> (amt - 1)) & 1 : 0; end
      10: r = b;
      default: r = a;
    endcase
    fl  = (r >= 32768 ? 8 : 0) + (r == 0 ? 4 : 0) + c * 2 + v;
    out = (op == 9) ? prev : r;
  endfunction

  task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] o, output logic [3:0] f, output logic e1,
                       output logic e2, output logic [15:0] o2, output logic [3:0] f2);
    en_in = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    @(posedge clk); #1;
    o = alu_out; f = flags; e1 = en_out;
    en_in = 1'b0; alu_a = 16'($urandom); alu_b = 16'($urandom); alu_op = 4'($urandom);
    @(posedge clk); #1;
    e2 = en_out; o2 = alu_out; f2 = flags;
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_run(input logic [15:0] a, input logic [15:0] b, input bit inject,
                         output logic [15:0] o, output logic [3:0] f, output int busy_n,
                         output int en_n, output int en_at, output logic [15:0] mid_out);
    en_in = 1'b1; alu_op = 4'd11; alu_a = a; alu_b = b;
    @(posedge clk); #1;
    en_in = 1'b0;
    busy_n = int'(busy); en_n = int'(en_out); en_at = -1;
    o = '0; f = '0; mid_out = '0;
    for (int i = 1; i <= 30; i++) begin
      if (inject && i == 5) begin
        en_in = 1'b1; alu_op = 4'd0; alu_a = 16'h0001; alu_b = 16'h0001;
      end
      @(posedge clk); #1;
      en_in = 1'b0;
      if (busy) busy_n++;
      if (en_out) begin en_n++; en_at = i; o = alu_out; f = flags; end
      if (i == 3) mid_out = alu_out;
    end
  endtask
`endif

  initial begin
    logic [15:0] o, o2;
    logic [3:0]  f, f2;
    logic        e1, e2;
    int          m_out, m_fl, model_out;
    logic [3:0]  op;
    logic [15:0] a, b;

    vecs.push_back('{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001});
    vecs.push_back('{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010});
    vecs.push_back('{4'd8,  16'h8001, 16'h0004, 16'hF800, 4'b1000});
    vecs.push_back('{4'd6,  16'h8001, 16'h0001, 16'h0002, 4'b0010});
    vecs.push_back('{4'd6,  16'h1234, 16'h0000, 16'h1234, 4'b0000});
    vecs.push_back('{4'd7,  16'h0003, 16'h0001, 16'h0001, 4'b0010});
    vecs.push_back('{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110});
    vecs.push_back('{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000});
    vecs.push_back('{4'd3,  16'h0000, 16'h0000, 16'h0000, 4'b0100});
    vecs.push_back('{4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100});
    vecs.push_back('{4'd5,  16'h0000, 16'h1111, 16'hFFFF, 4'b1000});
    vecs.push_back('{4'd13, 16'h55AA, 16'h0F0F, 16'h55AA, 4'b0000});
    vecs.push_back('{4'd10, 16'hBEEF, 16'h1234, 16'h1234, 4'b0000});
    vecs.push_back('{4'd9,  16'h00AA, 16'h00AA, 16'h1234, 4'b0100});

    repeat (3) @(posedge clk);
    #1;
    check("reset alu_out", 32'(alu_out), 32'h0);
    check("reset flags", 32'(flags), 32'h0);
    check("reset en_out", 32'(en_out), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, o, f, e1, e2, o2, f2);
      check($sformatf("vec%0d out", i), 32'(o), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d en_out pulse", i), 32'(e1), 32'h1);
      check($sformatf("vec%0d en_out drop", i), 32'(e2), 32'h0);
      check($sformatf("vec%0d hold out", i), 32'(o2), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d hold flags", i), 32'(f2), 32'(vecs[i].exp_flags));
    end

`ifndef ALU_MUL_EN
    apply(4'd11, 16'h55AA, 16'h1234, o, f, e1, e2, o2, f2);
    check("op11 reserved out", 32'(o), 32'h55AA);
    check("op11 reserved en_out", 32'(e1), 32'h1);
    check("op11 busy", 32'(busy), 32'h0);
`endif

    model_out = int'(vecs[vecs.size()-1].exp_out);
    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(15));
`ifdef ALU_MUL_EN
      if (op == 4'd11) op = 4'd12;
`endif
      a = 16'($urandom);
      b = (k % 3 == 0) ? 16'($urandom_range(17)) : 16'($urandom);
      ref_alu(int'(op), int'(a), int'(b), model_out, m_out, m_fl);
      model_out = m_out;
      apply(op, a, b, o, f, e1, e2, o2, f2);
      check($sformatf("rand%0d op%0d out", k, op), 32'(o), 32'(m_out));
      check($sformatf("rand%0d op%0d flags", k, op), 32'(f), 32'(m_fl));
      check($sformatf("rand%0d en_out", k), 32'(e1), 32'h1);
    end

`ifdef ALU_MUL_EN
    begin
      int busy_n, en_n, en_at;
      logic [15:0] mid;
      apply(4'd10, 16'h0, 16'h4321, o, f, e1, e2, o2, f2);
      mul_run(16'h0100, 16'h0200, 1'b1, o, f, busy_n, en_n, en_at, mid);
      check("mul1 out", 32'(o), 32'h0000);
      check("mul1 flags", 32'(f), 32'h6);
      check("mul1 busy cycles", 32'(busy_n), 32'd16);
      check("mul1 en_out count", 32'(en_n), 32'd1);
      check("mul1 en_out edge", 32'(en_at), 32'd16);
      check("mul1 hold during run", 32'(mid), 32'h4321);
      mul_run(16'h0007, 16'h0006, 1'b0, o, f, busy_n, en_n, en_at, mid);
      check("mul2 out", 32'(o), 32'd42);
      check("mul2 flags", 32'(f), 32'h0);
      check("mul2 en_out count", 32'(en_n), 32'd1);

      en_in = 1'b1; alu_op = 4'd11; alu_a = 16'h00FF; alu_b = 16'h00FF;
      @(posedge clk); #1;
      en_in = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midmul rst busy", 32'(busy), 32'h0);
      check("midmul rst en_out", 32'(en_out), 32'h0);
      check("midmul rst alu_out", 32'(alu_out), 32'h0);
      check("midmul rst flags", 32'(flags), 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      en_n = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (en_out) en_n++;
      end
      check("post rst no en_out", 32'(en_n), 32'h0);
      check("post rst busy", 32'(busy), 32'h0);
      check("post rst alu_out", 32'(alu_out), 32'h0);
    end
`else
    apply(4'd10, 16'h0, 16'hA5A5, o, f, e1, e2, o2, f2);
    #2;
    rst = 1'b0;
    #1;
    check("async rst alu_out", 32'(alu_out), 32'h0);
    check("async rst flags", 32'(flags), 32'h0);
    check("async rst en_out", 32'(en_out), 32'h0);
    check("async rst busy", 32'(busy), 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the ALU operand-select stage; consumes registered alu_a/alu_b plus the enable pulse.
- Performs the selected ALU operation and registers result and status flags.
- Emits a one-cycle en_out pulse to the write-back stage.
- Single-cycle ops complete in one clock; optional iterative multiply runs WIDTH cycles with busy asserted.

Parameters:
WIDTH, 16, datapath width; must be a power of two, at least 4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
en_in  input  1  operands valid this cycle (one-cycle pulse from operand stage)
alu_a  input  WIDTH  operand A (rd value)
alu_b  input  WIDTH  operand B (rs value or sign-extended offset)
alu_op  input  4  operation code, sampled with en_in
alu_out  output  WIDTH  registered result
flags  output  4  registered {N,Z,C,V}; bit3=N, bit2=Z, bit1=C, bit0=V
en_out  output  1  one-cycle pulse: alu_out/flags updated
busy  output  1  multi-cycle op in progress; en_in ignored while high

Behaviour:
- Reset (rst=0, async): alu_out=0, flags=0, en_out=0, busy=0, FSM=IDLE, counter=0. Takes effect mid-MUL; a partial product is discarded, no en_out.
- FSM states: IDLE, MUL_RUN. IDLE + en_in + op=MUL (feature enabled) -> MUL_RUN. MUL_RUN with counter==WIDTH-1 -> IDLE.
- Single-cycle ops: en_in=1 at edge N in IDLE -> alu_out/flags loaded and en_out=1 after edge N. en_out is 0 the following cycle unless en_in is again 1.
- en_in=0 in IDLE: en_out=0; alu_out and flags hold.
- Opcodes:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT (~a).
  - 6 SHL a<<b[log2W-1:0]; 7 SHR logical; 8 SAR arithmetic.
  - 9 CMP: computes a-b and updates flags only; alu_out holds; en_out still pulses.
  - 10 MOV: result=b.
  - 11 MUL.
  - 12-15 reserved: result=a, C=V=0.
- Flags:
  - Z = (result==0); N = result[WIDTH-1]. For CMP, both come from the internal difference.
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = borrow (a<b unsigned); V = signed overflow.
  - Shifts: C = last bit shifted out; shift amount 0 -> result=a, C=0. V=0.
  - Logic, MOV, NOT: C=V=0.
- All arithmetic is modulo 2^WIDTH; there is no sticky flag state.
- MUL (feature enabled), unsigned shift-add, one bit per cycle:
  - Operands latch at entry edge N; busy=1 after edge N.
  - Result, flags and en_out=1 appear after edge N+WIDTH; busy=0 at that same edge.
  - alu_out = low WIDTH bits; C = (high half != 0); V=0; Z and N from the low half.
- en_in while busy=1: ignored, with no queuing. Upstream must stall on busy.
- alu_out and flags hold their previous values throughout MUL_RUN.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL opcode, FSM MUL_RUN state, counter and multiplier sub-module are present; busy is driven as above.
- Undefined: opcode 11 is treated as reserved (result=a, single cycle); busy is tied to 0; no multiplier logic is instantiated.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD..OP_MUL);
  - flag bit indices (FLG_N, FLG_Z, FLG_C, FLG_V);
  - FSM state encodings (ST_IDLE, ST_MUL_RUN).
- One sub-module, alu_mul_seq (iterative shift-add multiplier):
  - inputs: start, a, b;
  - outputs: done pulse, 2*WIDTH product;
  - compiled only under ALU_MUL_EN.
- Top-level alu_exec holds the combinational op logic, flag logic, output registers and FSM.

Test Plan:
- Reset then ADD: a=16'h7FFF, b=16'h0001, op=0, en_in pulse -> next cycle alu_out=16'h8000, flags N=1 Z=0 C=0 V=1, en_out high exactly 1 cycle.
- SUB borrow: a=16'h0003, b=16'h0005 -> alu_out=16'hFFFE, C=1, N=1, V=0.
- CMP equal: alu_out preloaded 16'h1234; CMP a=b=16'h00AA -> Z=1, C=0, alu_out remains 16'h1234, en_out pulses.
- Shifts:
  - SAR a=16'h8001, b=4 -> alu_out=16'hF800, C=0.
  - SHL a=16'h8001, b=1 -> alu_out=16'h0002, C=1.
  - SHL with b=0 -> alu_out=a, C=0.
- MUL (ALU_MUL_EN):
  - a=16'h0100, b=16'h0200 -> busy high for 16 cycles; second en_in mid-run is ignored; alu_out=16'h0000, C=1, Z=1, single en_out.
  - a=7, b=6 -> alu_out=42, C=0.
- Reset mid-MUL: assert rst=0 at cycle 5 of MUL_RUN -> busy, en_out, alu_out, flags all 0 immediately; no en_out after release. Without ALU_MUL_EN, op=11 with a=16'h55AA -> alu_out=16'h55AA in 1 cycle, busy stays 0.
